// File: rtl/cordic_sched_pkg.sv
// Shared types for the CORDIC round-robin scheduler: FSM states and the
// requester tag that shadows each operand through the core pipeline.
package cordic_sched_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  // Tags are sized for the largest supported requester count so one type
  // serves every configuration; narrower builds leave the upper id bits zero.
  localparam int N_REQ_MAX = 8;
  localparam int ID_W      = ($clog2(N_REQ_MAX) < 1) ? 1 : $clog2(N_REQ_MAX);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr, wrapping, and reports the winner both one-hot and encoded.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  int   idx;
  logic found;

  // Scan upward from ptr with wrap; first valid requester wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/cordic_rr_sched.sv
// Round-robin front end sharing one fixed-latency CORDIC core among N_REQ
// requesters. Requester IDs ride a shadow tag pipe matched to the core
// latency and steer results back onto a shared response bus.
// Optional build macro CORDIC_SCHED_STATS_EN adds per-requester 16-bit
// saturating grant counters on port grant_cnt.
module cordic_rr_sched
  import cordic_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ANGLE_W  = 16,
  parameter int DATA_W   = 16,
  parameter int PIPE_LAT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sched_en,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ANGLE_W-1:0]   req_angle,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       core_in_valid,
  output logic [ANGLE_W-1:0]         core_in_angle,
  input  logic                       core_out_valid,
  input  logic [DATA_W-1:0]          core_out_x,
  input  logic [DATA_W-1:0]          core_out_y,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]          rsp_x,
  output logic [DATA_W-1:0]          rsp_y,
  output logic                       busy,
  output logic                       err_tag
`ifdef CORDIC_SCHED_STATS_EN
  ,output logic [N_REQ*16-1:0]       grant_cnt
`endif
);

  localparam int IW   = $clog2(N_REQ);
  localparam int IF_W = $clog2(PIPE_LAT + 2);

  sched_state_e        state, state_nx;
  logic [N_REQ-1:0]    gnt;
  logic [IW-1:0]       gnt_id;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       issue_id;
  logic                hs;
  tag_t                tag_pipe [PIPE_LAT];
  tag_t                tail;
  logic [IF_W-1:0]     inflight;
  logic                tag_unused;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (state == RUN),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready  = gnt;
  assign hs         = |gnt;
  assign tail       = tag_pipe[PIPE_LAT-1];
  assign tag_unused = ^tail.id;
  assign busy       = (state != HALT) || (inflight != '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= HALT;
    else     state <= state_nx;
  end

  // Next state: drain finishes only once nothing is issued or in the core.
  always_comb begin
    state_nx = state;
    case (state)
      HALT:    if (sched_en) state_nx = RUN;
      RUN:     if (!sched_en) state_nx = DRAIN;
      DRAIN: begin
        if (sched_en)                                  state_nx = RUN;
        else if (inflight == '0 && !core_in_valid)     state_nx = HALT;
      end
      default: state_nx = HALT;
    endcase
  end

  // Priority pointer moves past the last winner.
  always_ff @(posedge clk) begin
    if (rst)     ptr <= '0;
    else if (hs) ptr <= (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  // Issue register: operand and its owner launched the cycle after handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_in_valid <= 1'b0;
      core_in_angle <= '0;
      issue_id      <= '0;
    end else begin
      core_in_valid <= hs;
      if (hs) begin
        core_in_angle <= req_angle[gnt_id*ANGLE_W +: ANGLE_W];
        issue_id      <= gnt_id;
      end
    end
  end

  // Tag shadow pipe; its tail lines up with core_out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0].valid <= core_in_valid;
      tag_pipe[0].id    <= ID_W'(issue_id);
      for (int i = 1; i < PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Outstanding operations: handshaken but not yet retired at the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({hs, tail.valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Response register; data and id hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_x     <= '0;
      rsp_y     <= '0;
    end else begin
      rsp_valid <= core_out_valid && tail.valid;
      if (core_out_valid && tail.valid) begin
        rsp_id <= tail.id[IW-1:0];
        rsp_x  <= core_out_x;
        rsp_y  <= core_out_y;
      end
    end
  end

  // Sticky flag for any core strobe that does not match the tag tail.
  always_ff @(posedge clk) begin
    if (rst)                               err_tag <= 1'b0;
    else if (core_out_valid != tail.valid) err_tag <= 1'b1;
  end

`ifdef CORDIC_SCHED_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    logic [15:0] cnt;
    // Per-requester saturating handshake counter.
    always_ff @(posedge clk) begin
      if (rst)                               cnt <= '0;
      else if (gnt[g] && cnt != 16'hFFFF)    cnt <= cnt + 16'd1;
    end
    assign grant_cnt[g*16 +: 16] = cnt;
  end
`endif

endmodule
